key_expansion_engine: RTL and testbench
=======================================

// Module: key_expansion_engine
// PURPOSE
//  Sequential AES-256 key-schedule generator; writer side of the expanded-key bus read by the round-key controller.
//  Loads a 256-bit cipher key, then produces words w[8]..w[59] at one 32-bit word per clock.
//  Presents the 1920-bit schedule (15 x 128-bit round keys) on keyExp, bit 0 = MSB of w[0].
//  Sits between key input logic and the round-key controller/cipher core.
// PARAMETERS
//  NK  8   key length in 32-bit words (only 8 / AES-256 is supported and verified)
//  NR  14  cipher rounds; schedule length = 4*(NR+1) = 60 words = 1920 bits
// PORTS
//  clk          in   1     single clock, all logic on posedge
//  rst          in   1     synchronous, active-high reset
//  start        in   1     request expansion of key; sampled only in IDLE
//  key          in   256   cipher key [0:255], bit 0 = MSB of w[0]
//  keyExp       out  1920  expanded key [0:1919], w[i] at bits [32i:32i+31]
//  busy         out  1     high while in EXPAND
//  keyExpDone   out  1     one-cycle pulse on the cycle w[59] becomes visible
//  keyExpValid  out  1     level: schedule complete and stable; cleared by start or rst
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE; keyExp=0, busy=0, keyExpDone=0, keyExpValid=0; index=0, rcon=8'h01.
//  Reset mid-EXPAND: aborts immediately, same values as above; partial schedule discarded.
//  FSM: IDLE, EXPAND.
//   IDLE & start: keyExp[0:255]<=key, keyExp[256:1919]<=0, index<=8, rcon<=8'h01,
//     busy<=1, keyExpValid<=0, state<=EXPAND.
//   IDLE & !start: hold all outputs; keyExpDone<=0.
//   EXPAND, each posedge: write w[index] = w[index-8] ^ temp; index<=index+1.
//     temp = SubWord(RotWord(w[index-1])) ^ {rcon,24'h0}  when index%8==0; then rcon<=rcon<<1
//     temp = SubWord(w[index-1])                          when index%8==4
//     temp = w[index-1]                                   otherwise
//     RotWord({a,b,c,d}) = {b,c,d,a}; SubWord = AES S-box on each byte (combinational, same cycle).
//   EXPAND & index==59: write w[59], busy<=0, keyExpDone<=1, keyExpValid<=1, state<=IDLE.
//  Latency: start sampled at edge E0 -> keyExpDone/keyExpValid high after edge E0+52 (52 EXPAND writes).
//  rcon sequence at index 8,16,..,56: 01,02,04,08,10,20,40 (never exceeds 8'h40; no GF reduction required).
//  start while busy: ignored, no restart, no error.
//  start on the cycle keyExpDone is high (state already IDLE): accepted; keyExpValid drops, new expansion begins.
//  key is sampled only on the accepting edge; later key changes have no effect on the running expansion.
//  keyExp words above the current index read 0 during EXPAND; consumers use keyExp only while keyExpValid=1.
//  keyExp holds unchanged in IDLE until the next accepted start or rst.
// STRUCTURE
//  Shared package/include: AES_NK=8, AES_NR=14, AES_WORDS=60, RCON initial value 8'h01, word width 32.
//  Sub-module: aes_sbox (8-bit in, 8-bit out, combinational lookup), instantiated 4x for SubWord;
//   the same module is reused by the cipher SubBytes stage.
//  Datapath: index counter (6 bit), rcon register (8 bit), 1920-bit schedule register,
//   word-select muxes for w[index-1] and w[index-8].
// TESTING
//  1 FIPS-197 A.3 key 603deb10..0914dff4 -> after done, w8=9ba35411, w9=8e6925af, w12=a8b09c1a, w56..59=fe4890d1 e6188d0b 046df344 706c631e.
//  2 All-zero key -> w8..w11=62636363 each, w12..w15=aafbfbfb each; keyExp[0:255]=0.
//  3 Latency/handshake: start at edge E0 -> busy=1 from E0 to E0+51, keyExpDone pulse exactly after E0+52, keyExpValid held.
//  4 start pulsed at E0+10 mid-EXPAND with a different key -> ignored; result equals scenario 1 vectors.
//  5 rst asserted at E0+20 -> next cycle keyExp=0, busy=0, valid=0; fresh start then completes correctly at +52.
//  6 Back-to-back: start held high through done cycle -> second expansion starts, valid drops, completes 52 edges later.

Source files
------------

// File: rtl/key_expansion_engine_pkg.sv
// Shared AES key-schedule constants, FSM state type and word helpers.
// Imported by the key expansion engine and the S-box lookup.
package key_expansion_engine_pkg;

    localparam int unsigned AES_NK        = 8;
    localparam int unsigned AES_NR        = 14;
    localparam int unsigned AES_WORDS     = 4 * (AES_NR + 1);
    localparam int unsigned AES_WORD_W    = 32;
    localparam logic [7:0]  AES_RCON_INIT = 8'h01;

    typedef enum logic {
        ST_IDLE,
        ST_EXPAND
    } kx_state_t;

    // {a,b,c,d} -> {b,c,d,a}
    function automatic logic [AES_WORD_W-1:0] rot_word(input logic [AES_WORD_W-1:0] w);
        return {w[AES_WORD_W-9:0], w[AES_WORD_W-1:AES_WORD_W-8]};
    endfunction

endpackage

// File: rtl/key_expansion_engine_sbox.sv
// AES forward S-box, purely combinational byte lookup.
// Shared by the key schedule (SubWord) and the cipher SubBytes stage.
module aes_sbox
    import key_expansion_engine_pkg::*;
(
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_out = SBOX[i_in];

endmodule

// File: rtl/key_expansion_engine.sv
// Sequential AES-256 key schedule: loads the cipher key, then writes one
// schedule word per clock until all 60 words are present on keyExp.
module key_expansion_engine
    import key_expansion_engine_pkg::*;
#(
    parameter int unsigned NK = AES_NK,
    parameter int unsigned NR = AES_NR
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [0:32*NK-1]              key,
    output logic [0:32*4*(NR+1)-1]        keyExp,
    output logic                          busy,
    output logic                          keyExpDone,
    output logic                          keyExpValid
);

    localparam int unsigned WORDS   = 4 * (NR + 1);
    localparam int unsigned SCHED_W = WORDS * AES_WORD_W;
    localparam logic [5:0]  LAST_IX = 6'(WORDS - 1);
    localparam logic [5:0]  FIRST_IX = 6'(NK);

    kx_state_t              r_state;
    kx_state_t              w_state_nxt;
    logic [0:SCHED_W-1]     r_sched;
    logic [5:0]             r_index;
    logic [7:0]             r_rcon;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_valid;

    logic [10:0]            w_base_cur;
    logic [10:0]            w_base_prev;
    logic [10:0]            w_base_old;
    logic [31:0]            w_word_prev;
    logic [31:0]            w_word_old;
    logic [31:0]            w_sub_in;
    logic [31:0]            w_sub_out;
    logic [31:0]            w_temp;
    logic [31:0]            w_word_new;

    // Word i occupies bits [32i +: 32], so a bit offset is the word index with five zero LSBs.
    assign w_base_cur  = {r_index, 5'd0};
    assign w_base_prev = {r_index - 6'd1, 5'd0};
    assign w_base_old  = {r_index - FIRST_IX, 5'd0};
    assign w_word_prev = r_sched[w_base_prev +: 32];
    assign w_word_old  = r_sched[w_base_old +: 32];

    assign w_sub_in = (r_index[2:0] == 3'd0) ? rot_word(w_word_prev) : w_word_prev;

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_in  (w_sub_in[8*g +: 8]),
            .o_out (w_sub_out[8*g +: 8])
        );
    end

    always_comb begin
        w_temp = w_word_prev;
        case (r_index[2:0])
            3'd0:    w_temp = w_sub_out ^ {r_rcon, 24'h0};
            3'd4:    w_temp = w_sub_out;
            default: w_temp = w_word_prev;
        endcase
    end

    assign w_word_new = w_word_old ^ w_temp;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_EXPAND;
            ST_EXPAND: if (r_index == LAST_IX) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sched <= '0;
            r_index <= '0;
            r_rcon  <= AES_RCON_INIT;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sched <= {key, {(SCHED_W - 32*NK){1'b0}}};
                        r_index <= FIRST_IX;
                        r_rcon  <= AES_RCON_INIT;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    r_sched[w_base_cur +: 32] <= w_word_new;
                    r_index <= r_index + 6'd1;
                    if (r_index[2:0] == 3'd0) r_rcon <= r_rcon << 1;
                    if (r_index == LAST_IX) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign keyExp      = r_sched;
    assign busy        = r_busy;
    assign keyExpDone  = r_done;
    assign keyExpValid = r_valid;

endmodule

// File: tb/tb_key_expansion_engine.sv
// Directed bench for the AES-256 key schedule: FIPS-197 vectors, zero key,
// handshake timing, ignored mid-run start, mid-run reset and back-to-back start.
module tb_key_expansion_engine;

    logic           clk;
    logic           rst;
    logic           start;
    logic [0:255]   key;
    logic [0:1919]  keyExp;
    logic           busy;
    logic           keyExpDone;
    logic           keyExpValid;

    int unsigned    n_total;
    int unsigned    n_bad;

    logic [0:255]   key_a;
    logic [0:255]   key_z;

    key_expansion_engine #(
        .NK (8),
        .NR (14)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key         (key),
        .keyExp      (keyExp),
        .busy        (busy),
        .keyExpDone  (keyExpDone),
        .keyExpValid (keyExpValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wrd(input int unsigned i);
        return keyExp[32*i +: 32];
    endfunction

    function automatic logic [31:0] ones_all();
        return $countones(keyExp);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepting edge E0; returns 1ns after it.
    task automatic launch(input logic [0:255] k);
        key   = k;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Runs until keyExpDone (bounded), optionally pulsing start with another key at edge E0+mid.
    task automatic wait_done(input string tag, input int unsigned mid, input logic [0:255] mid_key);
        int unsigned done_edge;
        int unsigned n_busy;
        done_edge = 0;
        n_busy    = 0;
        for (int unsigned e = 1; e <= 60; e++) begin
            start = (e == mid);
            if (e == mid) key = mid_key;
            step();
            start = 1'b0;
            if (keyExpDone) begin
                done_edge = e;
                break;
            end
            if (busy) n_busy++;
        end
        check({tag, "_done_edge"}, done_edge, 52);
        check({tag, "_busy_cycles"}, n_busy, 51);
        check({tag, "_valid_at_done"}, {31'd0, keyExpValid}, 1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 0);
    endtask

    task automatic check_key_a(input string tag);
        check({tag, "_w0"},  wrd(0),  32'h603deb10);
        check({tag, "_w7"},  wrd(7),  32'h0914dff4);
        check({tag, "_w8"},  wrd(8),  32'h9ba35411);
        check({tag, "_w9"},  wrd(9),  32'h8e6925af);
        check({tag, "_w12"}, wrd(12), 32'ha8b09c1a);
        check({tag, "_w56"}, wrd(56), 32'hfe4890d1);
        check({tag, "_w57"}, wrd(57), 32'he6188d0b);
        check({tag, "_w58"}, wrd(58), 32'h046df344);
        check({tag, "_w59"}, wrd(59), 32'h706c631e);
    endtask

    task automatic check_key_z(input string tag);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < 8; i++) ones += $countones(wrd(i));
        check({tag, "_key_zero"}, ones, 0);
        for (int unsigned i = 8; i < 12; i++)  check({tag, "_w8_11"},  wrd(i), 32'h62636363);
        for (int unsigned i = 12; i < 16; i++) check({tag, "_w12_15"}, wrd(i), 32'haafbfbfb);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        key_a   = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
        key_z   = '0;
        rst     = 1'b1;
        start   = 1'b0;
        key     = '0;
        step();
        step();
        check("rst_keyexp_ones", ones_all(), 0);
        check("rst_busy",  {31'd0, busy}, 0);
        check("rst_done",  {31'd0, keyExpDone}, 0);
        check("rst_valid", {31'd0, keyExpValid}, 0);
        rst = 1'b0;
        step();

        // FIPS-197 A.3 key with handshake timing
        launch(key_a);
        check("s1_busy_e0", {31'd0, busy}, 1);
        check("s1_valid_e0", {31'd0, keyExpValid}, 0);
        check("s1_upper_clear", wrd(8), 0);
        wait_done("s1", 0, key_z);
        check_key_a("s1");
        key = key_z;
        step();
        check("s1_done_pulse", {31'd0, keyExpDone}, 0);
        check("s1_valid_held", {31'd0, keyExpValid}, 1);
        step();
        step();
        check("s1_hold_w59", wrd(59), 32'h706c631e);
        check("s1_hold_w0", wrd(0), 32'h603deb10);

        // Mid-run start with a different key is ignored
        launch(key_a);
        wait_done("s4", 10, key_z);
        check_key_a("s4");
        step();

        // Reset mid-expansion, then a fresh zero-key run
        launch(key_a);
        for (int unsigned e = 1; e < 20; e++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s5_keyexp_ones", ones_all(), 0);
        check("s5_busy",  {31'd0, busy}, 0);
        check("s5_valid", {31'd0, keyExpValid}, 0);
        check("s5_done",  {31'd0, keyExpDone}, 0);
        step();
        launch(key_z);
        wait_done("s5b", 0, key_z);
        check_key_z("s5b");
        step();

        // start held through the done cycle: second run begins on the next edge
        key   = key_a;
        start = 1'b1;
        step();
        for (int unsigned e = 1; e < 52; e++) begin
            if (e == 5) key = key_z;
            step();
        end
        step();
        check("s6_first_done", {31'd0, keyExpDone}, 1);
        check("s6_first_w59", wrd(59), 32'h706c631e);
        step();
        start = 1'b0;
        check("s6_restart_valid", {31'd0, keyExpValid}, 0);
        check("s6_restart_busy",  {31'd0, busy}, 1);
        check("s6_restart_done",  {31'd0, keyExpDone}, 0);
        check("s6_restart_w8",    wrd(8), 0);
        wait_done("s6b", 0, key_z);
        check_key_z("s6b");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
